// File: rtl/sequenciador_entrada_ula_pkg.sv
// ula_pkg: FSM state codes and ULA selector constants shared by the entry sequencer.
package ula_pkg;
  typedef enum logic [2:0] {
    CAP_A  = 3'd0,
    CAP_B  = 3'd1,
    CAP_OP = 3'd2,
    EMITE  = 3'd3,
    MOSTRA = 3'd4
  } estado_e;
  localparam logic [2:0] SEL_SOMA = 3'b000;
  localparam logic [2:0] SEL_SUB  = 3'b001;
  localparam logic [2:0] SEL_AND  = 3'b010;
  localparam logic [2:0] SEL_OR   = 3'b011;
  localparam logic [2:0] SEL_MULT = 3'b100;
  localparam logic [2:0] SEL_XOR  = 3'b101;
  localparam logic [2:0] SEL_DIV  = 3'b110;
  localparam logic [2:0] SEL_NADA = 3'b111;
endpackage

// File: rtl/sequenciador_entrada_ula_debounce_tecla.sv
// debounce_tecla: synchronizes and debounces one active-low key, emitting a one-cycle press pulse.
module debounce_tecla #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic nivel_o,
  output logic pulso_o
);
  logic [1:0]       sync_q;
  logic             nivel_q, nivel_d, pulso_q, pulso_d, muda, fim;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    muda    = sync_q[1] != nivel_q;
    fim     = muda && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    cnt_d   = (muda && !fim) ? cnt_q + 1'b1 : '0;
    nivel_d = fim ? sync_q[1] : nivel_q;
    pulso_d = fim && !sync_q[1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      nivel_q <= 1'b1;
      pulso_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      nivel_q <= nivel_d;
      pulso_q <= pulso_d;
      cnt_q   <= cnt_d;
    end
  end
  assign nivel_o = nivel_q;
  assign pulso_o = pulso_q;
endmodule

// File: rtl/sequenciador_entrada_ula.sv
// sequenciador_entrada_ula: key-driven operand/command entry FSM with valid/ready hand-off to the ULA.
module sequenciador_entrada_ula
  import ula_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sw,
  input  logic [1:0] key_n,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       cin,
  output logic [2:0] seletor,
  output logic       op_valid,
  input  logic       op_ready,
  input  logic [7:0] resultado,
  output logic [7:0] resultado_reg,
  output logic [2:0] estado
);
  logic       conf, canc, unused_niveis, unused_sw;
  logic [1:0] nivel;
  logic [2:0] state_q, state_d, sel_q, sel_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic       cin_q, cin_d;
  logic [7:0] res_q, res_d;
  debounce_tecla #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_conf (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_n[0]), .nivel_o(nivel[0]), .pulso_o(conf)
  );
  debounce_tecla #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_canc (
    .clk(clk), .rst_n(rst_n), .key_n_i(key_n[1]), .nivel_o(nivel[1]), .pulso_o(canc)
  );
  assign unused_niveis = &nivel;
  assign unused_sw     = sw[9];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CAP_A;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sel_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
    end
  end
  // EMITE ignores both keys so op_valid cannot drop before op_ready; codes 5-7 fall to CAP_A.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CAP_A:   state_d = canc ? CAP_A : conf ? CAP_B  : CAP_A;
      CAP_B:   state_d = canc ? CAP_A : conf ? CAP_OP : CAP_B;
      CAP_OP:  state_d = canc ? CAP_A : conf ? EMITE  : CAP_OP;
      EMITE:   state_d = op_ready ? MOSTRA : EMITE;
      MOSTRA:  state_d = (canc || conf) ? CAP_A : MOSTRA;
      default: state_d = CAP_A;
    endcase
  end
  always_comb begin
    op_valid = state_q == EMITE;
    a_d      = (state_q == CAP_A  && conf && !canc) ? sw[3:0] : a_q;
    cin_d    = (state_q == CAP_A  && conf && !canc) ? sw[8]   : cin_q;
    b_d      = (state_q == CAP_B  && conf && !canc) ? sw[7:4] : b_q;
    sel_d    = (state_q == CAP_OP && conf && !canc) ? sw[2:0] : sel_q;
    res_d    = (op_valid && op_ready) ? resultado : res_q;
  end
  assign a             = a_q;
  assign b             = b_q;
  assign cin           = cin_q;
  assign seletor       = sel_q;
  assign resultado_reg = res_q;
  assign estado        = state_q;
endmodule

// File: tb/tb_sequenciador_entrada_ula.sv
// tb_sequenciador_entrada_ula: randomized scenario bench against a key-event reference model.
module tb_sequenciador_entrada_ula;
  localparam int D = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] sw = '0;
  logic [1:0] key_n = 2'b11;
  logic       op_ready = 1'b0;
  logic [7:0] resultado = '0;
  logic [3:0] a, b;
  logic       cin, op_valid;
  logic [2:0] seletor, estado;
  logic [7:0] resultado_reg;
  int total = 0;
  int bad = 0;
  logic [3:0] m_a = '0, m_b = '0;
  logic       m_cin = 1'b0;
  logic [2:0] m_sel = '0, m_st = '0;
  logic [7:0] m_res = '0;

  sequenciador_entrada_ula #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .key_n(key_n), .a(a), .b(b), .cin(cin),
    .seletor(seletor), .op_valid(op_valid), .op_ready(op_ready), .resultado(resultado),
    .resultado_reg(resultado_reg), .estado(estado)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_a = '0; m_b = '0; m_cin = 1'b0; m_sel = '0; m_st = '0; m_res = '0;
  endtask

  // Holds the key(s) long enough to debounce, releases, then applies the event to the model.
  task automatic press(input logic conf, input logic canc);
    key_n = {~canc, ~conf};
    repeat (D + 5) @(negedge clk);
    key_n = 2'b11;
    repeat (D + 5) @(negedge clk);
    if (m_st == 3'd3) return;
    if (canc) m_st = 3'd0;
    else if (conf) begin
      case (m_st)
        3'd0: begin m_a = sw[3:0]; m_cin = sw[8]; m_st = 3'd1; end
        3'd1: begin m_b = sw[7:4]; m_st = 3'd2; end
        3'd2: begin
          m_sel = sw[2:0];
          m_st  = op_ready ? 3'd4 : 3'd3;
          if (op_ready) m_res = resultado;
        end
        default: m_st = 3'd0;
      endcase
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    total++; if (estado !== 3'd0) begin bad++; $display("FAIL reset_estado got=%0d want=0", estado); end
    total++; if (op_valid !== 1'b0) begin bad++; $display("FAIL reset_op_valid got=%0b want=0", op_valid); end
    total++; if ({a, b, cin, seletor, resultado_reg} !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", {a, b, cin, seletor, resultado_reg}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_flow();
    int nv = 0;
    logic [2:0] prev;
    sw = 10'b1_0000_0101;
    press(1'b1, 1'b0);
    total++; if (estado !== 3'd1) begin bad++; $display("FAIL flow_estado_b got=%0d want=1", estado); end
    total++; if (a !== 4'd5 || cin !== 1'b1) begin bad++; $display("FAIL flow_a got=%0d/%0b want=5/1", a, cin); end
    sw = 10'b00_0011_0000;
    press(1'b1, 1'b0);
    total++; if (estado !== 3'd2 || b !== 4'd3) begin bad++; $display("FAIL flow_b got=%0d/%0d want=2/3", estado, b); end
    sw = 10'b0; op_ready = 1'b1; resultado = 8'd9;
    prev = estado;
    key_n[0] = 1'b0;
    for (int i = 0; i < 2 * (D + 5); i++) begin
      if (i == D + 5) key_n = 2'b11;
      @(negedge clk);
      if (op_valid) nv++;
      if (estado !== prev) begin
        total++; if (estado !== prev + 3'd1) begin bad++; $display("FAIL flow_seq got=%0d want=%0d", estado, prev + 3'd1); end
        prev = estado;
      end
    end
    m_sel = 3'd0; m_res = 8'd9; m_st = 3'd4;
    total++; if (nv != 1) begin bad++; $display("FAIL flow_valid_cycles got=%0d want=1", nv); end
    total++; if (estado !== 3'd4 || resultado_reg !== 8'd9 || seletor !== 3'd0) begin bad++; $display("FAIL flow_mostra got=%0d/%0d/%0d want=4/9/0", estado, resultado_reg, seletor); end
    press(1'b1, 1'b0);
    total++; if (estado !== 3'd0) begin bad++; $display("FAIL flow_back got=%0d want=0", estado); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      sw = 10'($urandom);
      press(1'b1, 1'b0);
      sw = 10'($urandom);
      press(1'b1, 1'b0);
      total++; if (estado !== m_st || a !== m_a || cin !== m_cin || b !== m_b) begin bad++; $display("FAIL rand_ab got=%0d/%0d/%0b/%0d want=%0d/%0d/%0b/%0d", estado, a, cin, b, m_st, m_a, m_cin, m_b); end
      if ($urandom_range(0, 2) == 0) begin
        press(1'b0, 1'b1);
        total++; if (estado !== 3'd0 || b !== m_b) begin bad++; $display("FAIL rand_cancel got=%0d/%0d want=0/%0d", estado, b, m_b); end
        continue;
      end
      sw = 10'($urandom); resultado = 8'($urandom); op_ready = 1'b1;
      press(1'b1, 1'b0);
      total++; if (estado !== m_st || seletor !== m_sel || resultado_reg !== m_res || op_valid !== 1'b0) begin bad++; $display("FAIL rand_op got=%0d/%0d/%0d want=%0d/%0d/%0d", estado, seletor, resultado_reg, m_st, m_sel, m_res); end
      press($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      if (m_st != 3'd0) press(1'b1, 1'b0);
      total++; if (estado !== 3'd0) begin bad++; $display("FAIL rand_back got=%0d want=0", estado); end
    end
  endtask

  task automatic test_bounce();
    int lat = -1;
    for (int i = 0; i < 6; i++) begin
      key_n[0] = ~key_n[0];
      repeat (2) @(negedge clk);
    end
    total++; if (estado !== 3'd0) begin bad++; $display("FAIL bounce_early got=%0d want=0", estado); end
    sw = 10'($urandom);
    key_n[0] = 1'b0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (estado !== 3'd0) lat = i;
    end
    total++; if (lat < D + 2 || lat > D + 4) begin bad++; $display("FAIL bounce_latency got=%0d want=%0d..%0d", lat, D + 2, D + 4); end
    repeat (10) @(negedge clk);
    key_n = 2'b11;
    repeat (D + 5) @(negedge clk);
    m_a = sw[3:0]; m_cin = sw[8]; m_st = 3'd1;
    total++; if (estado !== 3'd1 || a !== m_a) begin bad++; $display("FAIL bounce_once got=%0d/%0d want=1/%0d", estado, a, m_a); end
  endtask

  task automatic test_emite_hold();
    logic stuck = 1'b0;
    sw = 10'($urandom);
    press(1'b1, 1'b0);
    op_ready = 1'b0;
    sw = 10'($urandom);
    press(1'b1, 1'b0);
    total++; if (estado !== 3'd3 || op_valid !== 1'b1) begin bad++; $display("FAIL emite_enter got=%0d/%0b want=3/1", estado, op_valid); end
    key_n[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sw = 10'($urandom);
      @(negedge clk);
      if (op_valid !== 1'b1 || estado !== 3'd3 || a !== m_a || b !== m_b || seletor !== m_sel) stuck = 1'b1;
    end
    key_n = 2'b11;
    repeat (D + 5) @(negedge clk);
    total++; if (stuck || estado !== 3'd3) begin bad++; $display("FAIL emite_hold got=%0d/%0b want=3/1", estado, op_valid); end
    resultado = 8'hC8; op_ready = 1'b1;
    @(negedge clk);
    m_res = 8'hC8; m_st = 3'd4;
    total++; if (estado !== 3'd4 || resultado_reg !== 8'd200 || op_valid !== 1'b0) begin bad++; $display("FAIL emite_done got=%0d/%0d/%0b want=4/200/0", estado, resultado_reg, op_valid); end
    press(1'b1, 1'b0);
  endtask

  task automatic test_simultaneous();
    sw = 10'b0_0000_1010;
    press(1'b1, 1'b0);
    sw = 10'b0_1110_0110;
    press(1'b1, 1'b1);
    total++; if (estado !== 3'd0 || a !== 4'd10 || b !== m_b) begin bad++; $display("FAIL both_keys got=%0d/%0d/%0d want=0/10/%0d", estado, a, b, m_b); end
  endtask

  task automatic test_reset_emite();
    sw = 10'($urandom);
    press(1'b1, 1'b0);
    op_ready = 1'b0;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    total++; if (op_valid !== 1'b1) begin bad++; $display("FAIL rst_pre got=%0b want=1", op_valid); end
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (op_valid !== 1'b0 || estado !== 3'd0) begin bad++; $display("FAIL rst_async got=%0b/%0d want=0/0", op_valid, estado); end
    total++; if ({a, b, cin, seletor, resultado_reg} !== '0) begin bad++; $display("FAIL rst_data got=%h want=0", {a, b, cin, seletor, resultado_reg}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (estado !== 3'd0 || op_valid !== 1'b0) begin bad++; $display("FAIL rst_after got=%0d want=0", estado); end
  endtask

  task automatic test_illegal();
    sw = 10'($urandom);
    press(1'b1, 1'b0);
    force dut.state_q = 3'd6;
    #1;
    release dut.state_q;
    #1;
    total++; if (estado !== 3'd6 || op_valid !== 1'b0) begin bad++; $display("FAIL illegal_forced got=%0d/%0b want=6/0", estado, op_valid); end
    @(negedge clk);
    m_st = 3'd0;
    total++; if (estado !== 3'd0 || op_valid !== 1'b0 || a !== m_a) begin bad++; $display("FAIL illegal_recover got=%0d/%0b want=0/0", estado, op_valid); end
  endtask

  initial begin
    test_reset();
    test_flow();
    test_random();
    test_bounce();
    test_emite_hold();
    test_simultaneous();
    test_reset_emite();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sequenciador_entrada_ula.md
# sequenciador_entrada_ula

Clocked operand/command entry sequencer that sits in front of the combinational ULA datapath and owns the KEY/SW input side of the board. It debounces the two push-buttons, walks the user through loading operand A (with carry-in), operand B and the 3-bit operation selector, then presents the operation to the ULA with a valid/ready handshake and captures the 8-bit result for display. It replaces the direct SW/KEY-to-datapath wiring, which changes with every switch movement.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a key level (10 ms at 50 MHz).
- `CNT_W`, 19: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- `clk`  in  1  system clock (50 MHz board clock).
- `rst_n`  in  1  asynchronous, active-low reset.
- `sw`  in  10  raw slide switches.
- `key_n`  in  2  raw push-buttons, active-low; `key_n[0]` = confirm, `key_n[1]` = cancel.
- `a`  out  4  latched operand A.
- `b`  out  4  latched operand B.
- `cin`  out  1  latched carry-in.
- `seletor`  out  3  latched operation code.
- `op_valid`  out  1  operation presented to the ULA.
- `op_ready`  in  1  ULA side accepts the operation and `resultado` is valid this cycle.
- `resultado`  in  8  ULA result.
- `resultado_reg`  out  8  captured result for the BCD/7-seg path.
- `estado`  out  3  current FSM state code, for the HEX5 indicator.

## Operation
- Each key: 2-flop synchronizer, then debounce. The debounced level updates only after the synchronized level differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce resets the counter.
- Press pulse: one cycle, generated on a debounced 1->0 transition. Release generates nothing.
- FSM states and codes:
  - CAP_A = 0: confirm latches `a`=`sw[3:0]` and `cin`=`sw[8]`, then goes to CAP_B.
  - CAP_B = 1: confirm latches `b`=`sw[7:4]`, then goes to CAP_OP.
  - CAP_OP = 2: confirm latches `seletor`=`sw[2:0]`, then goes to EMITE.
  - EMITE = 3: `op_valid`=1. On `op_valid && op_ready`, `resultado_reg`<=`resultado` and the FSM goes to MOSTRA.
  - MOSTRA = 4: confirm goes to CAP_A.
  - Codes 5–7 are illegal and recover to CAP_A on the next clock.
- Cancel pulse in CAP_A/CAP_B/CAP_OP/MOSTRA goes to CAP_A. Latched registers are kept.
- Cancel pulse in EMITE is ignored: `op_valid` must not drop before `op_ready`.
- Confirm and cancel pulses in the same cycle: cancel wins, except in EMITE, where both are ignored.
- `a`, `b`, `cin`, `seletor` are stable whenever `op_valid`=1.
- Reset values: state CAP_A, `a`=0, `b`=0, `cin`=0, `seletor`=0, `op_valid`=0, `resultado_reg`=0, `estado`=0, debounced levels=1 (released), counters=0.
- Reset mid-operation, including during EMITE, drops `op_valid` immediately (asynchronous) and discards the pending operation.

## Timing
- `key_n` goes low and stays low from cycle N: the press pulse is high in cycle N+2+`DEBOUNCE_CYCLES` (±1 for synchronizer phase). The state and operand registers update at the end of that cycle.
- `op_valid` is a decode of the registered state. It goes high in the first EMITE cycle, one cycle after the CAP_OP confirm pulse.
- With `op_ready` tied high, EMITE lasts exactly one cycle. `resultado_reg` is valid from the first MOSTRA cycle.
- `estado`, `op_valid` and all data outputs are registered or decoded from registered state only; there is no combinational path from `op_ready`/`sw` to outputs.

## Structure
- Package `ula_pkg`:
  - state enum: CAP_A, CAP_B, CAP_OP, EMITE, MOSTRA with the codes above;
  - selector constants: SEL_SOMA=000, SEL_SUB=001, SEL_AND=010, SEL_OR=011, SEL_MULT=100, SEL_XOR=101, SEL_DIV=110, SEL_NADA=111.
- Sub-module `debounce_tecla`, parameterized by `DEBOUNCE_CYCLES`/`CNT_W`, instanced twice. It contains the synchronizer, counter, debounced level and press pulse.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
1. Reset, then full flow: A with `sw`=10'b1_0000_0101; B with `sw[7:4]`=0011; OP with `sw[2:0]`=000; `op_ready`=1 -> `a`=5, `cin`=1, `b`=3, `seletor`=0, `op_valid` high one cycle, `resultado_reg`=9 when `resultado` is driven 9, `estado` sequence 0,1,2,3,4.
2. Bounce: confirm toggles low/high every 2 cycles for 12 cycles, then holds low -> exactly one pulse, emitted 2+4 cycles after the final low; state advances once.
3. `op_ready` held 0 for 20 cycles in EMITE while cancel is pressed -> `op_valid` stays 1, state stays 3. Raising `op_ready` with `resultado`=8'hC8 -> `resultado_reg`=200, MOSTRA.
4. Confirm and cancel pulses in the same cycle in CAP_B -> state CAP_A, `a` retained, `b` unchanged.
5. Assert `rst_n`=0 during EMITE -> `op_valid`=0 before the next clock edge; all outputs return to reset values; state CAP_A after release.
6. Force the state register to 6 -> CAP_A on the next clock; `op_valid`=0 throughout.
